// File: rtl/bcd_pkg.sv
// Shared BCD digit type and active-low 7-segment glyph table {a,b,c,d,e,f,g,dp}.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 8;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Segment pattern for one BCD digit; dp is always off.
    function automatic logic [SEG_W-1:0] seg_glyph(input digit_t digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'd0:    seg = 8'b0000_0011;
            4'd1:    seg = 8'b1001_1111;
            4'd2:    seg = 8'b0010_0101;
            4'd3:    seg = 8'b0000_1101;
            4'd4:    seg = 8'b1001_1001;
            4'd5:    seg = 8'b0100_1001;
            4'd6:    seg = 8'b0100_0001;
            4'd7:    seg = 8'b0001_1111;
            4'd8:    seg = 8'b0000_0001;
            4'd9:    seg = 8'b0000_1001;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Single BCD digit up/down step; cin requests a step, cout propagates wrap to the next digit.
import bcd_pkg::*;

module bcd_digit_cell (
    input  digit_t digit_i,
    input  logic   up_i,
    input  logic   cin_i,
    output digit_t next_c_o,
    output logic   cout_c_o
);

    always_comb begin
        next_c_o = digit_i;
        cout_c_o = 1'b0;
        if (cin_i) begin
            if (up_i) begin
                if (digit_i >= 4'd9) begin
                    next_c_o = 4'd0;
                    cout_c_o = 1'b1;
                end else begin
                    next_c_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    next_c_o = 4'd9;
                    cout_c_o = 1'b1;
                end else begin
                    next_c_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter_scan.sv
// Multi-digit BCD up/down counter with parallel load, wrap pulse and a
// time-multiplexed active-low 7-segment scan output.
import bcd_pkg::*;

module bcd_updown_counter_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned SCAN_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_tick,
    input  logic                  scan_tick,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic [DIGITS-1:0]     ssd_ctrl,
    output logic [SEG_W-1:0]      ssd
);

    localparam int unsigned CNT_W = DIGIT_W * DIGITS;

    logic [CNT_W-1:0]  count_q, count_d, stepped, load_clean;
    logic              carry_q, carry_d;
    logic [SCAN_W-1:0] idx_q, idx_d;
    logic [DIGITS-1:0] ctrl_q, ctrl_d;
    logic [SEG_W-1:0]  ssd_q, ssd_d;
    logic [DIGITS:0]   chain;
    digit_t            sel_digit;

    // Digit 0 always sees a step request; the whole chain is used only when a step is qualified.
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_digit_cell u_cell (
            .digit_i  (count_q[4*g +: 4]),
            .up_i     (up),
            .cin_i    (chain[g]),
            .next_c_o (stepped[4*g +: 4]),
            .cout_c_o (chain[g+1])
        );
    end

    always_comb begin
        load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clean[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd0 : load_val[4*k +: 4];
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (load) begin
            count_d = load_clean;
        end else if (count_tick && en) begin
            count_d = stepped;
            carry_d = chain[DIGITS];
        end
    end

    // Segment decode follows the next-state index and count so ssd and ssd_ctrl move together.
    always_comb begin
        idx_d = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == SCAN_W'(DIGITS - 1)) ? '0 : idx_q + SCAN_W'(1);
        end
        ctrl_d    = '1;
        sel_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == SCAN_W'(k)) begin
                ctrl_d[k] = 1'b0;
                sel_digit = count_d[4*k +: 4];
            end
        end
        ssd_d = seg_glyph(sel_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ctrl_q  <= ~DIGITS'(1);
            ssd_q   <= seg_glyph('0);
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            ctrl_q  <= ctrl_d;
            ssd_q   <= ssd_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign ssd_ctrl  = ctrl_q;
    assign ssd       = ssd_q;

endmodule

// File: tb/tb_bcd_updown_counter_scan.sv
// Scoreboard bench for bcd_updown_counter_scan using a decimal-integer reference model.
module tb_bcd_updown_counter_scan;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned MODV   = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        count_tick = 1'b0;
    logic        scan_tick = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        carry_out;
    logic [3:0]  ssd_ctrl;
    logic [7:0]  ssd;

    typedef struct packed {
        logic [15:0] cnt;
        logic        carry;
        logic [3:0]  ctrl;
        logic [7:0]  seg;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   mv = 0;
    int   midx = 0;
    logic mc = 1'b0;

    logic [7:0] glyph_tbl [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                   8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    bcd_updown_counter_scan #(.DIGITS(4), .SCAN_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_tick (count_tick),
        .scan_tick  (scan_tick),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .count      (count),
        .carry_out  (carry_out),
        .ssd_ctrl   (ssd_ctrl),
        .ssd        (ssd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    // Applies one clock of stimulus, advances the model and queues the expected outputs.
    task automatic drive(input logic r, input logic ld, input logic [15:0] lv,
                         input logic ct, input logic st, input logic e_i, input logic u);
        logic [3:0] one;
        int p;
        exp_t x;
        rst = r; load = ld; load_val = lv; count_tick = ct; scan_tick = st; en = e_i; up = u;
        mc = 1'b0;
        if (r) begin
            mv = 0;
            midx = 0;
        end else begin
            if (ld) begin
                mv = from_load(lv);
            end else if (ct && e_i) begin
                if (u) begin
                    if (mv == MODV - 1) begin mv = 0; mc = 1'b1; end
                    else mv = mv + 1;
                end else begin
                    if (mv == 0) begin mv = MODV - 1; mc = 1'b1; end
                    else mv = mv - 1;
                end
            end
            if (st) midx = (midx + 1) % DIGITS;
        end
        one = 4'b0001;
        p = 1;
        for (int i = 0; i < midx; i++) p = p * 10;
        x.cnt   = to_bcd(mv);
        x.carry = mc;
        x.ctrl  = ~(one << midx);
        x.seg   = glyph_tbl[(mv / p) % 10];
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
                failures++;
                $display("FAIL reset[%0d] got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                         i, count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
            end
        end
    endtask

    task automatic test_ripple();
        drive(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (e.cnt == 16'h1000 && (count !== 16'h1000 || carry_out !== 1'b0)) begin
                failures++;
                $display("FAIL ripple_fixed got cnt=%h c=%b exp cnt=1000 c=0", count, carry_out);
            end
        end
        checks++;
        if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
            failures++;
            $display("FAIL ripple got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                     count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
        end
    endtask

    task automatic test_up_wrap();
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 16'h0, i == 1, 1'b0, 1'b1, 1'b1);
            e = sb.pop_front();
            checks++;
            if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
                failures++;
                $display("FAIL up_wrap[%0d] got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                         i, count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
            end
        end
    endtask

    task automatic test_down_wrap();
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 16'h0, i < 3, 1'b0, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
                failures++;
                $display("FAIL down_wrap[%0d] got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                         i, count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1'b0, 1'b1, 16'h3C7A, 1'b1, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (count !== 16'h3070 || carry_out !== 1'b0 || {count, carry_out, ssd_ctrl, ssd} !== e) begin
            failures++;
            $display("FAIL load_priority got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                     count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
        end
    endtask

    task automatic test_scan();
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
                failures++;
                $display("FAIL scan[%0d] got ctrl=%b ssd=%b cnt=%h exp ctrl=%b ssd=%b cnt=%h",
                         i, ssd_ctrl, ssd, count, e.ctrl, e.seg, e.cnt);
            end
        end
    endtask

    task automatic test_enable_gating();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, i[0]);
            e = sb.pop_front();
        end
        checks++;
        if (count !== 16'h1234 || {count, carry_out, ssd_ctrl, ssd} !== e) begin
            failures++;
            $display("FAIL enable_gating got cnt=%h c=%b exp cnt=%h c=%b", count, carry_out, e.cnt, e.carry);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 16'h0998, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0), 16'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                checks++;
                if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
                    failures++;
                    $display("FAIL back_to_back_final got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                             count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
                end
            end
        end
    endtask

    // Per-cycle scoreboard check for back-to-back traffic: compares as each expected entry matures.
    task automatic test_random_stream();
        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), 16'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
            e = sb.pop_front();
            checks++;
            if ({count, carry_out, ssd_ctrl, ssd} !== e) begin
                failures++;
                $display("FAIL random[%0d] got cnt=%h c=%b ctrl=%b ssd=%b exp cnt=%h c=%b ctrl=%b ssd=%b",
                         i, count, carry_out, ssd_ctrl, ssd, e.cnt, e.carry, e.ctrl, e.seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_scan();
        test_enable_gating();
        test_back_to_back();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
